bram_readout: RTL and testbench

- Read-side engine for the 2K x 8 capture BRAM (11-bit address, 8-bit data, 1-cycle registered read with EN).
- On a start command, reads `length` bytes from `start_addr`, wrapping modulo 2048.
- Presents the bytes in order on a valid/ready byte stream toward the host-transfer path (UART/USB packetiser).
- Handles stream backpressure without dropping or duplicating bytes.

---
 rtl/bram_readout_pkg.sv | 16 +
 rtl/readout_skid_fifo.sv | 60 ++++++
 rtl/bram_readout.sv | 118 +++++++++++
 tb/tb_bram_readout.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_readout_pkg.sv
// bram_readout_pkg: shared widths, depth and FSM states
// for the capture BRAM read-side engine.
package bram_readout_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 8;
  localparam int BRAM_DEPTH = 2 ** DEF_ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FINISH
  } readout_state_t;

endpackage

// File: rtl/readout_skid_fifo.sv
// readout_skid_fifo: small circular buffer between the
// BRAM read return and the output byte stream.
module readout_skid_fifo #(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             push,
  input  logic [DATA_W-1:0]                din,
  input  logic                             pop,
  output logic [DATA_W-1:0]                dout,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(BUF_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // a pop frees the slot, so push into a full buffer is fine then
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/bram_readout.sv
// bram_readout: reads a span of the capture BRAM and streams
// the bytes out over valid/ready with full backpressure.
module bram_readout
  import bram_readout_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BUF_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int LW = ADDR_W + 1;
  localparam logic [LW-1:0] DEPTH = LW'(2 ** ADDR_W);

  readout_state_t state;
  readout_state_t state_nx;

  logic [ADDR_W-1:0] addr;
  logic [LW-1:0]     remaining;
  logic [LW-1:0]     len_c;
  logic              inflight;
  logic              issue;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [CW:0]       occ;

  assign len_c   = (length > DEPTH) ? DEPTH : length;
  assign m_valid = ~empty;
  assign pop     = m_valid & m_ready;

  // occupancy after this cycle's return and pop settle
  assign occ = {1'b0, count}
             + (CW+1)'(inflight)
             - (CW+1)'(pop);

  assign issue = (state == READ)
               & ~(full & ~pop)
               & (occ < (CW+1)'(BUF_DEPTH));

  assign bram_en   = issue;
  assign bram_addr = addr;
  assign busy      = (state == READ) | (state == DRAIN);
  assign done      = (state == FINISH);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (len_c == '0) ? FINISH : READ;
        end
      end
      READ: begin
        if (issue && remaining == LW'(1)) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && count == CW'(1) && !inflight) begin
          state_nx = FINISH;
        end
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      if (state == IDLE && start) begin
        addr      <= start_addr;
        remaining <= len_c;
      end else if (issue) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  readout_skid_fifo #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (inflight),
    .din   (bram_dout),
    .pop   (pop),
    .dout  (m_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_bram_readout.sv
// tb_bram_readout: randomized and directed checks of the
// readout engine against a queue-based transfer model.
module tb_bram_readout;

  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int BD    = 2;
  localparam int DEPTH = 2048;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy;
  logic          done;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_dout = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;

  logic [DW-1:0] mem [DEPTH];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_pct = 100;

  bram_readout #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .BUF_DEPTH (BD)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .bram_en    (bram_en),
    .bram_addr  (bram_addr),
    .bram_dout  (bram_dout),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (bram_en) bram_dout <= mem[bram_addr];
    cyc <= cyc + 1;
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1 m_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // transfer model
  bit            active = 0;
  logic [DW-1:0] exp_q[$];
  int            issues_left = 0;
  logic [AW-1:0] exp_addr = '0;
  int            start_cyc, first_en_cyc, last_en_cyc;
  int            first_v_cyc, done_cyc;
  int            n_deliv = 0;
  int            n_en = 0;
  int            n_done = 0;
  int            issued_tot = 0;
  int            hs_tot = 0;
  logic [DW-1:0] got[$];
  logic [AW-1:0] en_log[$];

  task automatic chk(input bit ok, input string nm,
                     input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  initial begin
    bit            prev_rst;
    bit            prev_stall;
    bit            was_active;
    bit            done_exp;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] a;
    int            n;
    prev_rst   = 0;
    prev_stall = 0;
    prev_data  = '0;
    forever begin
      @(negedge CLK);
      if (prev_rst && !RST) begin
        chk(busy == 0, "rst_busy", busy, 0);
        chk(done == 0, "rst_done", done, 0);
        chk(bram_en == 0, "rst_en", bram_en, 0);
        chk(m_valid == 0, "rst_valid", m_valid, 0);
        chk(m_data == 0, "rst_data", m_data, 0);
        chk(bram_addr == 0, "rst_addr", bram_addr, 0);
      end
      prev_rst = RST;
      if (RST) begin
        active = 0;
        exp_q.delete();
        issues_left = 0;
        issued_tot = 0;
        hs_tot = 0;
        prev_stall = 0;
      end else begin
        was_active = active;
        done_exp = active && exp_q.size() == 0
                   && issues_left == 0;
        chk(done == done_exp, "done", done, done_exp);
        chk(busy == (active && !done_exp), "busy",
            busy, active && !done_exp);
        if (done) begin
          n_done++;
          done_cyc = cyc;
        end
        if (prev_stall) begin
          chk(m_valid == 1, "hold_valid", m_valid, 1);
          chk(m_data == prev_data, "hold_data",
              m_data, prev_data);
        end
        if (bram_en) begin
          chk(issues_left > 0, "en_extra", issues_left, 1);
          chk(bram_addr == exp_addr, "en_addr",
              bram_addr, exp_addr);
          en_log.push_back(bram_addr);
          if (n_en == 0) first_en_cyc = cyc;
          last_en_cyc = cyc;
          n_en++;
          exp_addr++;
          issues_left--;
          issued_tot++;
        end
        if (m_valid) begin
          chk(exp_q.size() > 0, "valid_extra",
              exp_q.size(), 1);
          if (m_ready && exp_q.size() > 0) begin
            chk(m_data == exp_q[0], "data",
                m_data, exp_q[0]);
            got.push_back(m_data);
            if (n_deliv == 0) first_v_cyc = cyc;
            n_deliv++;
            void'(exp_q.pop_front());
            hs_tot++;
          end
        end
        chk(issued_tot - hs_tot <= BD, "occupancy",
            issued_tot - hs_tot, BD);
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (done_exp) active = 0;
        if (start && !was_active) begin
          active = 1;
          n = (int'(length) > DEPTH) ? DEPTH : int'(length);
          exp_q.delete();
          a = start_addr;
          for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem[a]);
            a++;
          end
          issues_left = n;
          exp_addr = start_addr;
          start_cyc = cyc;
          n_en = 0;
          n_deliv = 0;
          n_done = 0;
          issued_tot = 0;
          hs_tot = 0;
          got.delete();
          en_log.delete();
        end
      end
    end
  end

  task automatic do_start(input int a, input int l);
    @(posedge CLK);
    #1;
    start = 1;
    start_addr = AW'(a);
    length = (AW+1)'(l);
    @(posedge CLK);
    #1 start = 0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k;
    k = 0;
    while (active && k < budget) begin
      @(posedge CLK);
      k++;
    end
    chk(!active, nm, k, budget);
    repeat (2) @(posedge CLK);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
  endtask

  initial begin
    logic [DW-1:0] e_b[4];
    logic [AW-1:0] e_a[4];
    int            k;
    int            l;
    fill_ramp();
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    repeat (2) @(posedge CLK);

    // basic latency/throughput
    do_start(16, 4);
    wait_idle(50, "t1_timeout");
    e_b = '{8'h10, 8'h11, 8'h12, 8'h13};
    for (int i = 0; i < 4; i++)
      chk(i < got.size() && got[i] == e_b[i], "t1_byte",
          got[i], e_b[i]);
    chk(first_en_cyc - start_cyc == 1, "t1_en_first",
        first_en_cyc - start_cyc, 1);
    chk(last_en_cyc - start_cyc == 4, "t1_en_last",
        last_en_cyc - start_cyc, 4);
    chk(n_en == 4, "t1_en_count", n_en, 4);
    chk(first_v_cyc - start_cyc == 3, "t1_valid_first",
        first_v_cyc - start_cyc, 3);
    chk(done_cyc - start_cyc == 7, "t1_done_cyc",
        done_cyc - start_cyc, 7);
    chk(n_done == 1, "t1_done_count", n_done, 1);

    // wrap-around
    do_start(12'h7FE, 4);
    wait_idle(50, "t2_timeout");
    e_a = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    e_b = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    for (int i = 0; i < 4; i++) begin
      chk(i < en_log.size() && en_log[i] == e_a[i],
          "t2_addr", en_log[i], e_a[i]);
      chk(i < got.size() && got[i] == e_b[i],
          "t2_byte", got[i], e_b[i]);
    end

    // backpressure
    rdy_pct = 30;
    do_start(12'h123, 8);
    wait_idle(400, "t3_timeout");
    chk(n_deliv == 8, "t3_count", n_deliv, 8);
    chk(n_done == 1, "t3_done_count", n_done, 1);
    rdy_pct = 100;

    // zero length
    do_start(12'h055, 0);
    wait_idle(10, "t4_timeout");
    chk(n_en == 0, "t4_en_count", n_en, 0);
    chk(done_cyc - start_cyc == 1, "t4_done_cyc",
        done_cyc - start_cyc, 1);

    // clamped length
    do_start(12'h400, 3000);
    wait_idle(2200, "t5_timeout");
    chk(n_deliv == 2048, "t5_count", n_deliv, 2048);
    chk(done_cyc - start_cyc == 2051, "t5_done_cyc",
        done_cyc - start_cyc, 2051);

    // reset mid-transfer
    do_start(12'h200, 16);
    k = 0;
    while (n_deliv < 5 && k < 100) begin
      @(posedge CLK);
      k++;
    end
    chk(n_deliv == 5, "t6_reach5", n_deliv, 5);
    #1 RST = 1;
    @(posedge CLK);
    #1 RST = 0;
    @(posedge CLK);
    do_start(12'h100, 2);
    wait_idle(50, "t6_timeout");
    chk(got.size() == 2, "t6_count", got.size(), 2);
    chk(got.size() > 0 && got[0] == 8'h00, "t6_byte0",
        got[0], 8'h00);
    chk(got.size() > 1 && got[1] == 8'h01, "t6_byte1",
        got[1], 8'h01);

    // start while busy is ignored
    do_start(12'h020, 6);
    repeat (2) @(posedge CLK);
    #1;
    start = 1;
    start_addr = 11'h300;
    length = 12'd3;
    @(posedge CLK);
    #1 start = 0;
    wait_idle(50, "t7_timeout");
    repeat (5) @(posedge CLK);
    chk(n_done == 1, "t7_done_count", n_done, 1);
    chk(n_deliv == 6, "t7_count", n_deliv, 6);
    chk(n_en == 6, "t7_en_count", n_en, 6);
    chk(got.size() > 5 && got[5] == 8'h25, "t7_last",
        got[5], 8'h25);

    // randomized transfers
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      if (t % 8 == 7) begin
        l = $urandom_range(2040, 2100);
        rdy_pct = $urandom_range(60, 100);
      end else begin
        l = $urandom_range(0, 40);
        rdy_pct = $urandom_range(15, 100);
      end
      do_start($urandom_range(0, DEPTH - 1), l);
      if ($urandom_range(3) == 0) begin
        #2 start = 1;
        start_addr = AW'($urandom);
        length = (AW+1)'($urandom_range(1, 9));
        @(posedge CLK);
        #1 start = 0;
      end
      wait_idle(l * 12 + 60, "rand_timeout");
      chk(n_deliv == ((l > DEPTH) ? DEPTH : l), "rand_count",
          n_deliv, (l > DEPTH) ? DEPTH : l);
    end
    rdy_pct = 100;
    repeat (3) @(posedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
